// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front end (frame geometry, pixel/window types, window FSM states).
package cnn_pkg;
   localparam int DATA_W = 16;
   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int KSIZE  = 3;

   typedef logic signed [DATA_W-1:0] pixel_t;
   typedef pixel_t window_t [KSIZE*KSIZE];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } win_state_e;
endpackage

// File: rtl/line_buffer.sv
// Circular line buffer: one read and one write per cycle at the same pointer.
// Read is combinational, so the value leaving the buffer is the one written DEPTH accepts earlier.
module line_buffer #(
   parameter int DEPTH = 28,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_ptr;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_ptr <= '0;
      end else if (i_en) begin
         r_ptr <= (r_ptr == PTR_W'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
      end
   end

   // Storage is intentionally not reset; contents are don't-care until rows are filled.
   always_ff @(posedge clk) begin
      if (i_en) begin
         r_mem[r_ptr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[r_ptr];
endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: drives the image reader address and builds windows from
// its pixel stream with two line buffers and a 3x3 register array.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for start, address=0
// ST_STREAM | issuing addresses 1..IMG_W*IMG_H, accepting pixels
// ST_DRAIN  | all addresses issued, accepting remaining pixels
// ST_DONE   | one-cycle done pulse, then back to IDLE
module conv_window_gen
   import cnn_pkg::*;
#(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int IMG_W  = cnn_pkg::IMG_W,
   parameter int IMG_H  = cnn_pkg::IMG_H,
   parameter int ADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic                     start,
   output logic [ADDR_W-1:0]        address,
   output logic                     rd_en,
   input  logic signed [DATA_W-1:0] feat_in,
   input  logic                     feat_ready,
   output logic [9*DATA_W-1:0]      win_out,
   output logic                     win_valid,
   output logic [4:0]               win_row,
   output logic [4:0]               win_col,
   output logic                     busy,
   output logic                     done
);
   localparam int NWIN  = KSIZE*KSIZE;
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H+1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W*IMG_H);
   localparam logic [4:0] LAST_WROW = 5'(IMG_H-KSIZE);
   localparam logic [4:0] LAST_WCOL = 5'(IMG_W-KSIZE);

   win_state_e r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic signed [DATA_W-1:0] r_win [NWIN];
   logic signed [DATA_W-1:0] w_win_nxt [NWIN];
   logic signed [DATA_W-1:0] w_lb0_q, w_lb1_q;
   logic [9*DATA_W-1:0] r_win_out;
   logic r_win_valid;
   logic [4:0] r_win_row, r_win_col;
   logic w_busy, w_accept, w_win_ok, w_frame_go;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_STREAM;
         end
         ST_STREAM: begin
            w_busy = 1'b1;
            if (r_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (r_win_valid && r_win_row == LAST_WROW && r_win_col == LAST_WCOL)
               w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy       = w_busy;
   assign rd_en      = w_busy;
   assign w_frame_go = (r_state == ST_IDLE) && start;
   assign w_accept   = w_busy && feat_ready;
   assign w_win_ok   = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_addr <= '0;
      end else if (w_frame_go) begin
         r_addr <= ADDR_W'(1);
      end else if (r_state == ST_STREAM && r_addr != LAST_ADDR) begin
         r_addr <= r_addr + 1'b1;
      end else begin
         r_addr <= '0;
      end
   end

   assign address = r_addr;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_frame_go) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (r_col == COL_W'(IMG_W-1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   // lb1 delays the stream by one row, lb0 re-delays lb1's output by another row.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
      .clk       (clk),
      .n_reset   (n_reset),
      .i_en      (w_accept),
      .i_wr_data (feat_in),
      .o_rd_data (w_lb1_q)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
      .clk       (clk),
      .n_reset   (n_reset),
      .i_en      (w_accept),
      .i_wr_data (w_lb1_q),
      .o_rd_data (w_lb0_q)
   );

   always_comb begin
      w_win_nxt = r_win;
      for (int r = 0; r < KSIZE; r++) begin
         for (int c = 0; c < KSIZE-1; c++) begin
            w_win_nxt[r*KSIZE+c] = r_win[r*KSIZE+c+1];
         end
      end
      w_win_nxt[KSIZE-1]        = w_lb0_q;
      w_win_nxt[2*KSIZE-1]      = w_lb1_q;
      w_win_nxt[KSIZE*KSIZE-1]  = feat_in;
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_win       <= '{default: '0};
         r_win_out   <= '0;
         r_win_valid <= 1'b0;
         r_win_row   <= '0;
         r_win_col   <= '0;
      end else begin
         r_win_valid <= w_win_ok;
         if (w_accept) r_win <= w_win_nxt;
         if (w_win_ok) begin
            for (int i = 0; i < NWIN; i++) begin
               r_win_out[DATA_W*i +: DATA_W] <= w_win_nxt[i];
            end
            r_win_row <= 5'(r_row - ROW_W'(2));
            r_win_col <= 5'(r_col - COL_W'(2));
         end
      end
   end

   assign win_out   = r_win_out;
   assign win_valid = r_win_valid;
   assign win_row   = r_win_row;
   assign win_col   = r_win_col;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: models a 1-cycle image reader (with optional stall) and
// checks every window against a scoreboard built from the known image contents.
module tb_conv_window_gen;
   localparam int DW = 16;
   localparam int W  = 28;
   localparam int H  = 28;
   localparam int NW = (W-2)*(H-2);

   typedef struct {
      int          row;
      int          col;
      logic [143:0] win;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic n_reset = 1'b0;
   logic start = 1'b0;
   logic [15:0] address;
   logic rd_en;
   logic signed [DW-1:0] feat_in = '0;
   logic feat_ready = 1'b0;
   logic [9*DW-1:0] win_out;
   logic win_valid;
   logic [4:0] win_row, win_col;
   logic busy, done;

   int checks = 0;
   int errors = 0;
   int cyc_cnt = 0;
   int c0 = 0;
   bit frame_active = 0;
   int img_mode = 0;
   int stall_pix = -1;
   int win_cnt, done_cnt, first_cyc, last_cyc, done_cyc;
   exp_t sb[$];
   int rq[$];
   logic [143:0] seen [NW];

   int rd_a, rd_p, stall_left;
   logic rd_rs;
   bit stall_done;

   conv_window_gen dut (
      .clk        (clk),
      .n_reset    (n_reset),
      .start      (start),
      .address    (address),
      .rd_en      (rd_en),
      .feat_in    (feat_in),
      .feat_ready (feat_ready),
      .win_out    (win_out),
      .win_valid  (win_valid),
      .win_row    (win_row),
      .win_col    (win_col),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc_cnt++;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] pix(input int mode, input int p);
      logic signed [DW-1:0] v;
      v = (mode != 0) ? DW'(-p) : DW'(p);
      return v;
   endfunction

   function automatic logic [143:0] model_win(input int mode, input int r, input int c);
      logic [143:0] w;
      w = '0;
      for (int i = 0; i < 9; i++) begin
         w[DW*i +: DW] = pix(mode, (r + i/3)*W + c + i%3);
      end
      return w;
   endfunction

   function automatic logic [143:0] pack9(input int v0, input int v1, input int v2,
                                          input int v3, input int v4, input int v5,
                                          input int v6, input int v7, input int v8);
      logic [143:0] w;
      w = {DW'(v8), DW'(v7), DW'(v6), DW'(v5), DW'(v4), DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
      return w;
   endfunction

   // Image reader model: address seen in one cycle yields its pixel the next cycle;
   // a stall holds feat_in and queues further addresses.
   initial begin
      stall_left = 0;
      stall_done = 0;
      forever begin
         @(negedge clk);
         rd_a  = int'(address);
         rd_rs = n_reset;
         @(posedge clk);
         #1;
         if (!rd_rs || !n_reset) begin
            rq.delete();
            feat_ready = 1'b0;
            stall_left = 0;
         end else begin
            if (rd_a == 1) stall_done = 0;
            if (rd_a != 0) rq.push_back(rd_a - 1);
            if (stall_left > 0) begin
               stall_left--;
               feat_ready = 1'b0;
            end else if (rq.size() > 0 && rq[0] == stall_pix && !stall_done) begin
               stall_done = 1;
               stall_left = 4;
               feat_ready = 1'b0;
            end else if (rq.size() > 0) begin
               exp_t e;
               rd_p = rq.pop_front();
               feat_in = pix(img_mode, rd_p);
               feat_ready = 1'b1;
               if (rd_p / W >= 2 && rd_p % W >= 2) begin
                  e.row = rd_p / W - 2;
                  e.col = rd_p % W - 2;
                  e.win = model_win(img_mode, e.row, e.col);
                  e.cyc = cyc_cnt + 1;
                  sb.push_back(e);
               end
            end else begin
               feat_ready = 1'b0;
            end
         end
      end
   end

   // Output monitor
   initial forever begin
      int n;
      @(negedge clk);
      n = cyc_cnt - c0 + 1;
      if (frame_active) begin
         chk("addr_seq", address, (n >= 1 && n <= W*H) ? n : 0);
         if (done) begin
            done_cnt++;
            done_cyc = n;
            chk("busy_at_done", {busy, rd_en}, 2'b00);
         end
      end
      if (win_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_win", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("win_row", win_row, e.row);
            chk("win_col", win_col, e.col);
            chk("win_data", win_out, e.win);
            chk("win_cycle", cyc_cnt, e.cyc);
            if (e.row >= 0 && e.row < H-2 && e.col >= 0 && e.col < W-2)
               seen[e.row*(W-2) + e.col] = win_out;
         end
         win_cnt++;
         if (frame_active) begin
            if (first_cyc < 0) first_cyc = n;
            last_cyc = n;
         end
      end
   end

   task automatic run_frame(input int mode, input int stall_at, input bit repulse,
                            input int abort_at, input int exp_done, input int exp_last);
      int n;
      bit finished;
      img_mode  = mode;
      stall_pix = stall_at;
      win_cnt = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
      sb.delete();
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      c0 = cyc_cnt;
      frame_active = 1;
      finished = 0;
      for (int k = 0; k < 1000 && !finished; k++) begin
         n = cyc_cnt - c0 + 1;
         if (repulse && n == 400) start = 1'b1;
         if (repulse && n == 401) start = 1'b0;
         if (abort_at > 0 && n == abort_at) begin
            frame_active = 0;
            n_reset = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk("reset_outs", {address, rd_en, win_valid, busy, done, win_row, win_col, win_out}, '0);
            end
            @(posedge clk); #1;
            n_reset = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            sb.delete();
            finished = 1;
         end else if (done_cnt > 0 && n >= done_cyc + 2) begin
            finished = 1;
         end else begin
            @(posedge clk); #1;
         end
      end
      frame_active = 0;
      if (!finished) chk("frame_timeout", 0, 1);
      if (abort_at > 0) begin
         chk("abort_no_done", done_cnt, 0);
      end else begin
         chk("win_count", win_cnt, NW);
         chk("done_count", done_cnt, 1);
         chk("done_cycle", done_cyc, exp_done);
         chk("first_win_cycle", first_cyc, 61);
         chk("last_win_cycle", last_cyc, exp_last);
         chk("sb_empty", sb.size(), 0);
         chk("idle_after", {busy, rd_en, done, address}, '0);
      end
   endtask

   initial begin
      #(500_000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 n_reset = 1'b1;
      // Idle with start low
      repeat (10) begin
         @(negedge clk);
         chk("idle_outs", {address, rd_en, win_valid, busy, done, win_row, win_col, win_out}, '0);
      end

      // Ramp frame
      run_frame(0, -1, 0, 0, 787, 786);
      chk("ramp_first", seen[0], pack9(0, 1, 2, 28, 29, 30, 56, 57, 58));
      chk("ramp_last", seen[NW-1], pack9(725, 726, 727, 753, 754, 755, 781, 782, 783));

      // Signed frame
      run_frame(1, -1, 0, 0, 787, 786);
      chk("neg_r3c5", seen[3*(W-2)+5], pack9(-89, -90, -91, -117, -118, -119, -145, -146, -147));

      // Reader stall of 5 cycles at pixel 300
      run_frame(0, 300, 0, 0, 792, 791);
      chk("stall_r8c18", seen[8*(W-2)+18], pack9(242, 243, 244, 270, 271, 272, 298, 299, 300));
      chk("stall_last", seen[NW-1], pack9(725, 726, 727, 753, 754, 755, 781, 782, 783));

      // start re-pulsed mid-frame
      run_frame(0, -1, 1, 0, 787, 786);

      // Abort by reset at cycle 200, then a clean frame
      run_frame(0, -1, 0, 200, 0, 0);
      run_frame(0, -1, 0, 0, 787, 786);
      chk("rerun_first", seen[0], pack9(0, 1, 2, 28, 29, 30, 56, 57, 58));
      chk("rerun_last", seen[NW-1], pack9(725, 726, 727, 753, 754, 755, 781, 782, 783));

      repeat (5) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
